// File: rtl/store_narrower.sv
// MEM-stage store-data formatter: narrows a register value to byte/half/word, replicates it across
// lanes, builds byte enables, and buffers results in a 2-entry skid FIFO. Optional macro: MISALIGN_TRAP_EN.
module store_narrower #(
    parameter int WL  = 32,
    parameter int HWL = 16,
    localparam int NB = WL / 8
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WL-1:0] Data,
    input  logic [1:0]    Size,
    input  logic [1:0]    Addr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WL-1:0] WData,
    output logic [NB-1:0] BE,
    output logic          Misaligned,
    output logic          Err,
    output logic [1:0]    buf_state
);

    // Handshake: a side transfers on a rising CLK edge where its valid and ready are both high;
    // valid never depends on ready, and a presented head holds stable until it is taken.

    typedef struct packed {
        logic [WL-1:0] wdata;
        logic [NB-1:0] be;
        logic          mis;
        logic          err;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state, next_state;
    entry_t head, tail, fmt;
    logic   in_fire, out_fire;
    logic   head_load_new, head_load_tail, tail_load;

    always_comb begin
        fmt       = '0;
        fmt.wdata = Data;
        case (Size)
            2'b00: begin
                fmt.wdata = {NB{Data[7:0]}};
                fmt.be    = {{(NB-1){1'b0}}, 1'b1} << Addr;
            end
            2'b01: begin
                fmt.wdata = {(WL/HWL){Data[HWL-1:0]}};
                fmt.be    = {{(NB-2){1'b0}}, 2'b11} << {Addr[1], 1'b0};
`ifdef MISALIGN_TRAP_EN
                if (Addr[0]) begin
                    fmt.be  = '0;
                    fmt.mis = 1'b1;
                end
`endif
            end
            2'b10: begin
                fmt.be = '1;
`ifdef MISALIGN_TRAP_EN
                if (Addr != 2'b00) begin
                    fmt.be  = '0;
                    fmt.mis = 1'b1;
                end
`endif
            end
            default: begin
                fmt.be  = '0;
                fmt.err = 1'b1;
            end
        endcase
    end

    // in_ready is forced low while reset is asserted, even though the state is already EMPTY.
    assign in_ready  = RSTn && (state != TWO);
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        next_state     = state;
        head_load_new  = 1'b0;
        head_load_tail = 1'b0;
        tail_load      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    next_state    = ONE;
                    head_load_new = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    head_load_new = 1'b1;
                end else if (in_fire) begin
                    next_state = TWO;
                    tail_load  = 1'b1;
                end else if (out_fire) begin
                    next_state = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    next_state     = ONE;
                    head_load_tail = 1'b1;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            state <= next_state;
            if (head_load_new) begin
                head <= fmt;
            end else if (head_load_tail) begin
                head <= tail;
            end
            if (tail_load) begin
                tail <= fmt;
            end
        end
    end

    assign WData      = head.wdata;
    assign BE         = head.be;
    assign Misaligned = head.mis;
    assign Err        = head.err;
    assign buf_state  = state;

endmodule
